// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: channel inputs, select controls and registered output stream; master drives inputs, slave is the mux
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int NCH = 4,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0] in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_ready;
  logic mode;
  logic [SELW-1:0] sel;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_ready;
  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NCH-to-1 stream mux, manual or round-robin grant, registered output; clk/rst plain, stream on bus (slave), optional xfer_cnt with STREAM_MUX_CNT_EN
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH = 4
) (
  input logic clk,
  input logic rst,
  stream_mux_rr_if.slave bus
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  logic load, gnt_v, xfer;
  logic [SELW-1:0] gnt;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d, ptr_q, ptr_d;
  // round-robin scan runs backwards so the channel closest to ptr wins
  always_comb begin
    gnt = bus.sel;
    gnt_v = (32'(bus.sel) < NCH) ? bus.in_valid[bus.sel] : 1'b0;
    if (bus.mode) begin
      gnt = '0;
      gnt_v = 1'b0;
      for (int k = NCH - 1; k >= 0; k--)
        if (bus.in_valid[(32'(ptr_q) + k) % NCH]) begin
          gnt = SELW'((32'(ptr_q) + k) % NCH);
          gnt_v = 1'b1;
        end
    end
  end
  assign load = !out_valid_q || bus.out_ready;
  assign xfer = gnt_v && load && !rst;
  assign bus.in_ready = xfer ? NCH'(1) << gnt : '0;
  always_comb begin
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d = xfer ? bus.in_data[32'(gnt)*WIDTH +: WIDTH] : out_data_q;
    out_ch_d = xfer ? gnt : out_ch_q;
    ptr_d = (xfer && bus.mode) ? SELW'((32'(gnt) + 1) % NCH) : ptr_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      ptr_q <= ptr_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_ch = out_ch_q;
`ifdef STREAM_MUX_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  assign xfer_cnt_d = (out_valid_q && bus.out_ready) ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
  always_ff @(posedge clk)
    if (rst) xfer_cnt_q <= '0;
    else xfer_cnt_q <= xfer_cnt_d;
  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: randomized and directed checks of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  stream_mux_rr_if #(.WIDTH(4), .NCH(4)) b ();
  stream_mux_rr_if #(.WIDTH(4), .NCH(3)) b3 ();
`ifdef STREAM_MUX_CNT_EN
  logic [15:0] cnt, cnt3;
  stream_mux_rr #(.WIDTH(4), .NCH(4)) dut (.clk(clk), .rst(rst), .bus(b), .xfer_cnt(cnt));
  stream_mux_rr #(.WIDTH(4), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3), .xfer_cnt(cnt3));
`else
  stream_mux_rr #(.WIDTH(4), .NCH(4)) dut (.clk(clk), .rst(rst), .bus(b));
  stream_mux_rr #(.WIDTH(4), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
`endif
  always #5 clk = ~clk;
  bit mv;
  logic [3:0] md;
  int mc, mptr, mcnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic int grant();
    if (!b.mode) return b.in_valid[b.sel] ? int'(b.sel) : -1;
    for (int k = 0; k < 4; k++)
      if (b.in_valid[(mptr + k) % 4]) return (mptr + k) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    mv = 0; md = 0; mc = 0; mptr = 0; mcnt = 0;
  endtask
  task automatic cyc();
    int g;
    bit load;
    logic [3:0] er;
    @(negedge clk);
    load = !mv || b.out_ready;
    g = grant();
    er = (rst || !load || g < 0) ? 4'b0 : 4'b1 << g;
    chk("in_ready", b.in_ready, er);
    chk("out_valid", b.out_valid, mv);
    chk("out_data", b.out_data, md);
    chk("out_ch", b.out_ch, mc);
`ifdef STREAM_MUX_CNT_EN
    chk("xfer_cnt", cnt, mcnt[15:0]);
`endif
    if (rst) model_reset();
    else begin
      if (mv && b.out_ready) mcnt++;
      if (load) begin
        mv = (g >= 0);
        if (g >= 0) begin
          md = b.in_data[g*4 +: 4];
          mc = g;
          if (b.mode) mptr = (g + 1) % 4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    b.in_valid = 4'hF; b.in_data = 16'h1234; b.mode = 0; b.sel = 0; b.out_ready = 1;
    b3.in_valid = 3'b111; b3.in_data = 12'h987; b3.mode = 0; b3.sel = 2'd3; b3.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b.in_ready, 4'b0);
    chk("rst_out_valid", b.out_valid, 1'b0);
    chk("rst_out_data", b.out_data, 4'h0);
    chk("rst_out_ch", b.out_ch, 2'd0);
    rst = 0;
    model_reset();
    // manual select of channel 2
    b.in_valid = 4'b0110; b.in_data = 16'h0A30; b.sel = 2; #1;
    chk("man_in_ready", b.in_ready, 4'b0100);
    chk("oor_in_ready", b3.in_ready, 3'b0);
    cyc();
    chk("man_valid", b.out_valid, 1'b1);
    chk("man_data", b.out_data, 4'hA);
    chk("man_ch", b.out_ch, 2'd2);
    repeat (3) cyc();
    chk("oor_out_valid", b3.out_valid, 1'b0);
    chk("oor_in_ready2", b3.in_ready, 3'b0);
    b3.sel = 2'd2; #1;
    chk("nch3_in_ready", b3.in_ready, 3'b100);
    cyc();
    chk("nch3_ch", b3.out_ch, 2'd2);
    chk("nch3_data", b3.out_data, 4'h9);
    // round robin from ptr 0 over all-valid inputs, covering the wrap
    b.mode = 1; b.in_valid = 4'hF; b.in_data = 16'hDCBA;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_seq", b.out_ch, i % 4);
    end
    // backpressure hold of word 5
    b.mode = 0; b.sel = 1; b.in_valid = 4'b0010; b.in_data = 16'h0050;
    cyc();
    chk("bp_data", b.out_data, 4'h5);
    b.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b.in_valid = 4'($urandom); b.in_data = 16'($urandom); b.sel = 2'($urandom);
      cyc();
      chk("bp_hold", b.out_data, 4'h5);
      chk("bp_ready", b.in_ready, 4'b0);
    end
    b.out_ready = 1; b.sel = 3; b.in_valid = 4'b1000; b.in_data = 16'hC000; #1;
    chk("bp_release", b.in_ready, 4'b1000);
    cyc();
    chk("bp_next", b.out_data, 4'hC);
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      b.in_valid = 4'($urandom); b.in_data = 16'($urandom);
      b.mode = ($urandom_range(0, 3) != 0); b.sel = 2'($urandom);
      b.out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 0;
    // reset while a word is held
    b.mode = 0; b.sel = 0; b.in_valid = 4'b0001; b.in_data = 16'h0007; b.out_ready = 0;
    cyc();
    cyc();
    chk("mid_valid", b.out_valid, 1'b1);
    rst = 1;
    cyc();
    chk("mid_rst_valid", b.out_valid, 1'b0);
    chk("mid_rst_data", b.out_data, 4'h0);
    rst = 0; b.mode = 1; b.in_valid = 4'hF; b.out_ready = 1; #1;
    chk("mid_rst_ptr", b.in_ready, 4'b0001);
    cyc();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
